// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// Optional ABORT input is enabled by defining SEQ_PATTERN_TX_ABORT_EN.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Default pattern matches the team's 1101 Mealy detector
    localparam int                           DEFAULT_PATTERN_W = 4;
    localparam logic [DEFAULT_PATTERN_W-1:0] DEFAULT_PATTERN   = 4'b1101;
    localparam int                           DEFAULT_GAP       = 1;

    localparam int GAP_CNT_W = 4;
    localparam int REP_CNT_W = 8;

    // Number of BUSY cycles a transmission of reps repetitions occupies
    function automatic int frame_cycles(input int reps, input int pattern_w, input int gap);
        return reps * (pattern_w + gap);
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle between a requester and seq_pattern_tx.
// ABORT exists only when SEQ_PATTERN_TX_ABORT_EN is defined.
interface seq_pattern_tx_if;

    logic       START;
    logic [7:0] REPS;
    logic       SOUT;
    logic       BUSY;
    logic       LAST_BIT;
    logic       DONE;
`ifdef SEQ_PATTERN_TX_ABORT_EN
    logic       ABORT;
`endif

    modport master (
        input  SOUT, BUSY, LAST_BIT, DONE,
`ifdef SEQ_PATTERN_TX_ABORT_EN
        output ABORT,
`endif
        output START, REPS
    );

    modport slave (
        output SOUT, BUSY, LAST_BIT, DONE,
`ifdef SEQ_PATTERN_TX_ABORT_EN
        input  ABORT,
`endif
        input  START, REPS
    );

endinterface

// File: rtl/seq_pattern_tx_piso_shift.sv
// Parallel-in serial-out register; MSB leaves first, zeros fill from the LSB.
module piso_shift #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;

    // Zero fill means the register drains to all-zero once a pattern is sent
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= data;
        end else if (shift_en) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: REPS repetitions of PATTERN, MSB-first, GAP zeros after each.
// Define SEQ_PATTERN_TX_ABORT_EN to add the ABORT input.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int                   PATTERN_W = DEFAULT_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN,
    parameter int                   GAP       = DEFAULT_GAP
) (
    input logic             CLK,
    input logic             RST_N,
    seq_pattern_tx_if.slave bus
);

    localparam int                   BIT_W    = $clog2(PATTERN_W);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(PATTERN_W - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;
    localparam bit                   HAS_GAP  = (GAP > 0);

    state_t                 state_q, state_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [GAP_CNT_W-1:0]   gap_q, gap_d;
    logic [REP_CNT_W-1:0]   rep_q, rep_d;
    logic                   busy_q, busy_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   piso_load;
    logic                   piso_shift;
    logic [PATTERN_W-1:0]   piso_data;
    logic                   sout;
    logic                   abort_req;

`ifdef SEQ_PATTERN_TX_ABORT_EN
    assign abort_req = bus.ABORT;
`else
    assign abort_req = 1'b0;
`endif

    piso_shift #(
        .WIDTH (PATTERN_W)
    ) u_piso (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (piso_load),
        .shift_en (piso_shift),
        .data     (piso_data),
        .msb      (sout)
    );

    // Next state, counters and shifter control; outputs are derived from the next state
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        rep_d      = rep_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_data  = PATTERN;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    if (bus.REPS != '0) begin
                        state_d   = S_SHIFT;
                        rep_d     = bus.REPS;
                        bit_d     = '0;
                        piso_load = 1'b1;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_SHIFT: begin
                if (bit_q == BIT_LAST) begin
                    rep_d = rep_q - 8'd1;
                    bit_d = '0;
                    if (HAS_GAP) begin
                        state_d    = S_GAP;
                        gap_d      = '0;
                        piso_shift = 1'b1;
                    end else if (rep_d != '0) begin
                        piso_load = 1'b1;
                    end else begin
                        state_d    = S_FIN;
                        piso_shift = 1'b1;
                    end
                end else begin
                    bit_d      = bit_q + 1'b1;
                    piso_shift = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (rep_q != '0) begin
                        state_d   = S_SHIFT;
                        bit_d     = '0;
                        piso_load = 1'b1;
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                bit_d   = '0;
                gap_d   = '0;
                rep_d   = '0;
            end
        endcase

        // Abort overrides any transition; loading zeros silences SOUT at once
        if (abort_req && (state_q == S_SHIFT || state_q == S_GAP)) begin
            state_d    = S_IDLE;
            bit_d      = '0;
            gap_d      = '0;
            rep_d      = '0;
            piso_load  = 1'b1;
            piso_shift = 1'b0;
            piso_data  = '0;
        end

        busy_d = (state_d == S_SHIFT) || (state_d == S_GAP);
        last_d = (state_d == S_SHIFT) && (bit_d == BIT_LAST);
        done_d = (state_d == S_FIN);
    end

    // State, counters and registered status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign bus.SOUT     = sout;
    assign bus.BUSY     = busy_q;
    assign bus.LAST_BIT = last_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a GAP=1 and a GAP=0 instance checked cycle by cycle against a frame model.
// Exercises ABORT when SEQ_PATTERN_TX_ABORT_EN is defined.
module tb_seq_pattern_tx;

    localparam int         PW  = 4;
    localparam logic [3:0] PAT = 4'b1101;

    logic CLK = 1'b0;
    logic RST_N;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    always #5 CLK = ~CLK;

    seq_pattern_tx_if busA ();
    seq_pattern_tx_if busB ();

    seq_pattern_tx #(.PATTERN_W(PW), .PATTERN(PAT), .GAP(1)) dutA (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (busA)
    );

    seq_pattern_tx #(.PATTERN_W(PW), .PATTERN(PAT), .GAP(0)) dutB (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (busB)
    );

    task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic start, input logic [7:0] reps);
        if (sel == 0) begin
            busA.START = start;
            busA.REPS  = reps;
        end else begin
            busB.START = start;
            busB.REPS  = reps;
        end
    endtask

    // {SOUT, BUSY, LAST_BIT, DONE}
    function automatic logic [3:0] observe(input int sel);
        if (sel == 0) return {busA.SOUT, busA.BUSY, busA.LAST_BIT, busA.DONE};
        return {busB.SOUT, busB.BUSY, busB.LAST_BIT, busB.DONE};
    endfunction

    // Expected outputs in cycle k (k=1 is the first cycle after START is accepted)
    function automatic logic [3:0] expectedOut(input int reps, input int gap, input int k);
        logic [3:0] pat;
        int frameLen;
        int busyN;
        int idx;
        pat = PAT;
        if (reps == 0) return (k == 1) ? 4'b0001 : 4'b0000;
        frameLen = PW + gap;
        busyN    = reps * frameLen;
        if (k <= busyN) begin
            idx = (k - 1) % frameLen;
            if (idx < PW) return {pat[PW-1-idx], 1'b1, (idx == PW - 1), 1'b0};
            return 4'b0100;
        end
        if (k == busyN + 1) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic checkAll(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checkOutput({tag, " SOUT"},     {8'd0, obs[3]}, {8'd0, exp[3]});
        checkOutput({tag, " BUSY"},     {8'd0, obs[2]}, {8'd0, exp[2]});
        checkOutput({tag, " LAST_BIT"}, {8'd0, obs[1]}, {8'd0, exp[1]});
        checkOutput({tag, " DONE"},     {8'd0, obs[0]}, {8'd0, exp[0]});
    endtask

    // One transmission, checked per cycle; SOUT also feeds a 1101 detector model
    task automatic runFrame(input int sel, input int reps, input bit repulse);
        int         gap;
        int         busyN;
        int         total;
        int         busySeen;
        int         yCount;
        int         detCnt;
        bit         swallow;
        bit         detY;
        logic [3:0] hist;
        logic [3:0] obs;
        string      tag;
        gap      = (sel == 0) ? 1 : 0;
        busyN    = reps * (PW + gap);
        total    = (reps == 0) ? 2 : busyN + 2;
        busySeen = 0;
        yCount   = 0;
        detCnt   = 0;
        swallow  = 1'b0;
        hist     = 4'b0000;
        $display("[TB] frame dut=%0d reps=%0d repulse=%0d", sel, reps, repulse);
        applyStimulus(sel, 1'b1, 8'(reps));
        @(negedge CLK);
        for (int k = 1; k <= total; k++) begin
            obs = observe(sel);
            tag = $sformatf("dut%0d reps%0d k%0d", sel, reps, k);
            checkAll(tag, obs, expectedOut(reps, gap, k));
            if (obs[2] === 1'b1) busySeen++;
            detY = 1'b0;
            if (swallow) begin
                swallow = 1'b0;
            end else begin
                hist = {hist[2:0], obs[3]};
                detCnt++;
                if (detCnt >= 4 && hist == 4'b1101) begin
                    detY    = 1'b1;
                    swallow = 1'b1;
                    detCnt  = 0;
                end
            end
            if (detY) begin
                yCount++;
                if (gap > 0) checkOutput({tag, " det_y_with_last"}, {8'd0, obs[1]}, 9'd1);
            end
            if (k < total && repulse) applyStimulus(sel, (k == total - 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                                                    8'($urandom_range(0, 255)));
            else applyStimulus(sel, 1'b0, 8'd0);
            @(negedge CLK);
        end
        checkOutput($sformatf("dut%0d reps%0d busy_cycles", sel, reps), 9'(busySeen), 9'(busyN));
        checkOutput($sformatf("dut%0d reps%0d det_y_count", sel, reps), 9'(yCount),
                    9'((gap > 0) ? reps : (reps + 1) / 2));
    endtask

    initial begin
        int sel;
        int reps;
        $display("[TB] start");
        RST_N = 1'b0;
        applyStimulus(0, 1'b0, 8'd0);
        applyStimulus(1, 1'b0, 8'd0);
`ifdef SEQ_PATTERN_TX_ABORT_EN
        busA.ABORT = 1'b0;
        busB.ABORT = 1'b0;
`endif
        #1;
        checkAll("reset A", observe(0), 4'b0000);
        checkAll("reset B", observe(1), 4'b0000);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checkAll("idle A", observe(0), 4'b0000);

        runFrame(0, 1, 1'b0);
        runFrame(0, 3, 1'b0);
        runFrame(1, 2, 1'b0);
        runFrame(1, 3, 1'b0);
        runFrame(0, 0, 1'b0);
        runFrame(1, 0, 1'b1);
        runFrame(0, 2, 1'b1);
        runFrame(1, 3, 1'b1);

        for (int i = 0; i < 8; i++) begin
            sel  = int'($urandom_range(0, 1));
            reps = int'($urandom_range(0, 5));
            runFrame(sel, reps, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a 3-repetition transmission
        applyStimulus(0, 1'b1, 8'd3);
        @(negedge CLK);
        applyStimulus(0, 1'b0, 8'd0);
        checkAll("pre-reset k1", observe(0), expectedOut(3, 1, 1));
        @(negedge CLK);
        checkAll("pre-reset k2", observe(0), expectedOut(3, 1, 2));
        #2 RST_N = 1'b0;
        #1 checkAll("mid reset A", observe(0), 4'b0000);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checkAll($sformatf("post reset %0d", k), observe(0), 4'b0000);
        end

`ifdef SEQ_PATTERN_TX_ABORT_EN
        applyStimulus(0, 1'b1, 8'd2);
        @(negedge CLK);
        applyStimulus(0, 1'b0, 8'd0);
        @(negedge CLK);
        checkAll("abort k2", observe(0), 4'b1100);
        busA.ABORT = 1'b1;
        @(negedge CLK);
        busA.ABORT = 1'b0;
        checkAll("abort k3", observe(0), 4'b0000);
        for (int k = 4; k < 8; k++) begin
            @(negedge CLK);
            checkAll($sformatf("abort k%0d", k), observe(0), 4'b0000);
        end
`else
        runFrame(0, 2, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
